vc_output_arbiter: RTL and testbench

VC_OUTPUT_ARBITER -- requirements
Module: vc_output_arbiter

---
 rtl/vc_output_arbiter_pkg.sv | 20 ++
 rtl/vc_output_arbiter_rr_arbiter.sv | 52 +++++
 rtl/vc_output_arbiter.sv | 87 ++++++++
 tb/tb_vc_output_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vc_output_arbiter_pkg.sv
// Shared NoC definitions: flit geometry, VC count and flit-type codes.
// Used by the output arbiter and by the VC buffers that feed it.
package vc_output_arbiter_pkg;

  localparam int NOC_FLIT_WIDTH  = 34;
  localparam int NOC_VC_ID_WIDTH = 2;
  localparam int NOC_NUM_VC      = 4;
  localparam int NOC_TYPE_LSB    = 32;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b00,
    FLIT_BODY = 2'b01,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [NOC_FLIT_WIDTH-1:0] flit);
    return flit_type_e'(flit[NOC_TYPE_LSB +: 2]);
  endfunction

endpackage

// File: rtl/vc_output_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, searching upward
// from a rotating pointer that moves past the winner whenever update is set.
module rr_arbiter
  import vc_output_arbiter_pkg::*;
#(
  parameter int N = NOC_NUM_VC
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] win_s;
  logic [PW-1:0] nxt_s;
  logic          found_s;
  logic [N-1:0]  gnt_s;

  // First requester at or above the pointer, wrapping modulo N
  always_comb begin
    gnt_s   = '0;
    found_s = 1'b0;
    idx_s   = ptr_r;
    win_s   = ptr_r;
    for (int i = 0; i < N; i++) begin
      idx_s        = PW'((int'(ptr_r) + i) % N);
      gnt_s[idx_s] = req[idx_s] & ~found_s;
      win_s        = (req[idx_s] && !found_s) ? idx_s : win_s;
      found_s      = found_s | req[idx_s];
    end
    nxt_s = (int'(win_s) == N - 1) ? '0 : win_s + PW'(1);
  end

  // Pointer moves only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (!arst) begin
      ptr_r <= '0;
    end else if (update && found_s) begin
      ptr_r <= nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/vc_output_arbiter.sv
// Per-flit round-robin arbitration of NUM_VC candidate flits onto one link,
// through a single output register with per-VC downstream backpressure.
module vc_output_arbiter
  import vc_output_arbiter_pkg::*;
#(
  parameter int NUM_VC      = NOC_NUM_VC,
  parameter int FLIT_WIDTH  = NOC_FLIT_WIDTH,
  parameter int VC_ID_WIDTH = NOC_VC_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_VC*FLIT_WIDTH-1:0] fdata_i,
  input  logic [NUM_VC-1:0]            valid_i,
  output logic [NUM_VC-1:0]            ready_o,
  output logic [FLIT_WIDTH-1:0]        fdata_o,
  output logic [VC_ID_WIDTH-1:0]       vc_id_o,
  output logic                         valid_o,
  input  logic [NUM_VC-1:0]            ready_i
);

  logic [FLIT_WIDTH-1:0]  fdata_r;
  logic [VC_ID_WIDTH-1:0] vc_r;
  logic                   valid_r;

  logic                   consumed_s;
  logic                   slot_free_s;
  logic                   grant_en_s;
  logic                   any_gnt_s;
  logic [NUM_VC-1:0]      gnt_s;
  logic [FLIT_WIDTH-1:0]  fsel_s;
  logic [VC_ID_WIDTH-1:0] gidx_s;

  rr_arbiter #(
    .N (NUM_VC)
  ) u_rr_arbiter (
    .clk    (clk),
    .arst   (arst),
    .req    (valid_i),
    .update (grant_en_s),
    .gnt    (gnt_s)
  );

  // Slot is free when empty or draining this cycle; grant and mux the winner
  always_comb begin
    consumed_s  = valid_r & ready_i[vc_r];
    slot_free_s = ~valid_r | consumed_s;
    grant_en_s  = slot_free_s & arst;
    if (grant_en_s) begin
      ready_o = gnt_s;
    end else begin
      ready_o = '0;
    end
    any_gnt_s = |ready_o;
    fsel_s    = '0;
    gidx_s    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      fsel_s = fsel_s | (gnt_s[v] ? fdata_i[v*FLIT_WIDTH +: FLIT_WIDTH] : '0);
      gidx_s = gidx_s | (gnt_s[v] ? VC_ID_WIDTH'(v) : '0);
    end
  end

  // Output register: load on grant, drop valid on drain, otherwise hold
  always_ff @(posedge clk) begin
    if (!arst) begin
      fdata_r <= '0;
      vc_r    <= '0;
      valid_r <= 1'b0;
    end else if (any_gnt_s) begin
      fdata_r <= fsel_s;
      vc_r    <= gidx_s;
      valid_r <= 1'b1;
    end else if (consumed_s) begin
      fdata_r <= fdata_r;
      vc_r    <= vc_r;
      valid_r <= 1'b0;
    end else begin
      fdata_r <= fdata_r;
      vc_r    <= vc_r;
      valid_r <= valid_r;
    end
  end

  assign fdata_o = fdata_r;
  assign vc_id_o = vc_r;
  assign valid_o = valid_r;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Randomized and directed bench for vc_output_arbiter against a behavioural
// link model and a per-VC in-order scoreboard.
module tb_vc_output_arbiter;
  import vc_output_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int FW = 34;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            arst;
  logic [N*FW-1:0] fdata_i;
  logic [N-1:0]    valid_i;
  logic [N-1:0]    ready_o;
  logic [FW-1:0]   fdata_o;
  logic [IW-1:0]   vc_id_o;
  logic            valid_o;
  logic [N-1:0]    ready_i;

  vc_output_arbiter #(.NUM_VC(N), .FLIT_WIDTH(FW), .VC_ID_WIDTH(IW)) dut (
    .clk     (clk),
    .arst    (arst),
    .fdata_i (fdata_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .fdata_o (fdata_o),
    .vc_id_o (vc_id_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  // upstream sources, in-flight scoreboard and link model
  logic [FW-1:0] src_q[N][$];
  logic [FW-1:0] sb[N][$];
  logic [N-1:0]  gate;
  bit            m_v   = 1'b0;
  logic [FW-1:0] m_d   = '0;
  int            m_vc  = 0;
  int            m_ptr = 0;

  task automatic check_eq(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic refill_all();
    for (int v = 0; v < N; v++) begin
      while (src_q[v].size() < 4) begin
        src_q[v].push_back({2'($urandom), 8'(v), 24'(seq)});
        seq++;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int v = 0; v < N; v++) begin
      if (gate[v] && src_q[v].size() > 0) begin
        valid_i[v]             = 1'b1;
        fdata_i[v*FW +: FW]    = src_q[v][0];
      end else begin
        valid_i[v]             = 1'b0;
        fdata_i[v*FW +: FW]    = '0;
      end
    end
  endtask

  // VC the link should accept this cycle, or -1
  function automatic int model_pick();
    if (!arst) return -1;
    if (m_v && !ready_i[m_vc]) return -1;
    for (int k = 0; k < N; k++) begin
      if (valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update();
    int g;
    if (!arst) begin
      if (m_v) void'(sb[m_vc].pop_back());
      m_v = 1'b0; m_d = '0; m_vc = 0; m_ptr = 0;
    end else begin
      g = model_pick();
      if (g >= 0) begin
        sb[g].push_back(src_q[g].pop_front());
        m_d   = fdata_i[g*FW +: FW];
        m_vc  = g;
        m_v   = 1'b1;
        m_ptr = (g + 1) % N;
      end else if (m_v && ready_i[m_vc]) begin
        m_v = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    int g;
    int ov;
    logic [N-1:0] exp_r;
    drive_inputs();
    @(negedge clk);
    g = model_pick();
    exp_r = '0;
    if (g >= 0) exp_r[g] = 1'b1;
    check_eq("ready_o", FW'(ready_o), FW'(exp_r));
    check_eq("valid_o", FW'(valid_o), FW'(m_v));
    check_eq("vc_id_o", FW'(vc_id_o), FW'(m_vc));
    check_eq("fdata_o", fdata_o, m_d);
    if (arst && valid_o && ready_i[vc_id_o]) begin
      ov = int'(vc_id_o);
      check_eq("sb_nonempty", FW'(sb[ov].size() > 0), FW'(1));
      if (sb[ov].size() > 0) check_eq("sb_order", fdata_o, sb[ov].pop_front());
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [FW-1:0] held;
  logic [1:0]    got0[$];
  int            cnt3;

  initial begin
    arst = 1'b0; ready_i = '1; gate = '1; valid_i = '0; fdata_i = '0;
    refill_all();
    drive_inputs();
    @(posedge clk); #1;

    // reset with all VCs requesting
    repeat (2) cycle();
    check_eq("rst_ready", FW'(ready_o), FW'(0));
    check_eq("rst_valid", FW'(valid_o), FW'(0));
    check_eq("rst_fdata", fdata_o, FW'(0));
    check_eq("rst_vc", FW'(vc_id_o), FW'(0));

    // full-rate rotation 0,1,2,3,0
    arst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("rot_vc", FW'(vc_id_o), FW'(k % N));
      check_eq("rot_valid", FW'(valid_o), FW'(1));
    end

    // single VC2 flit
    gate = '0;
    repeat (2) cycle();
    src_q[2].delete();
    src_q[2].push_back(34'h2_0000_0005);
    gate = 4'b0100;
    drive_inputs(); #1;
    check_eq("vc2_ready", FW'(ready_o), FW'(4'b0100));
    cycle();
    check_eq("vc2_fdata", fdata_o, 34'h2_0000_0005);
    check_eq("vc2_vc", FW'(vc_id_o), FW'(2));
    check_eq("vc2_valid", FW'(valid_o), FW'(1));

    // VC1 flit stalled by downstream, then VC2 wins
    refill_all();
    gate = 4'b0010;
    cycle();
    held = m_d;
    gate = '1; ready_i = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      drive_inputs(); #1;
      check_eq("stall_ready", FW'(ready_o), FW'(0));
      cycle();
      check_eq("stall_fdata", fdata_o, held);
    end
    ready_i = '1;
    drive_inputs(); #1;
    check_eq("unstall_ready", FW'(ready_o), FW'(4'b0100));
    cycle();

    // VC0 packet interleaved with VC3
    gate = '0;
    repeat (2) cycle();
    for (int v = 0; v < N; v++) src_q[v].delete();
    src_q[0].push_back({FLIT_HEAD, 32'hA0});
    src_q[0].push_back({FLIT_BODY, 32'hA1});
    src_q[0].push_back({FLIT_TAIL, 32'hA2});
    for (int k = 0; k < 3; k++) src_q[3].push_back({2'($urandom), 32'hB0 + 32'(k)});
    gate = 4'b1001;
    cnt3 = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (valid_o && vc_id_o == 2'd0) got0.push_back(2'(flit_type(fdata_o)));
      if (valid_o && vc_id_o == 2'd3) cnt3++;
    end
    check_eq("pkt_vc0_count", FW'(got0.size()), FW'(3));
    check_eq("pkt_vc3_count", FW'(cnt3), FW'(3));
    for (int k = 0; k < got0.size(); k++)
      check_eq("pkt_type", FW'(got0[k]), (k == 0) ? FW'(FLIT_HEAD) : (k == 1) ? FW'(FLIT_BODY) : FW'(FLIT_TAIL));

    // reset while a flit is on the link, then restart from VC0
    refill_all();
    gate = '1; ready_i = '0;
    repeat (2) cycle();
    arst = 1'b0;
    cycle();
    check_eq("mid_rst_valid", FW'(valid_o), FW'(0));
    arst = 1'b1; gate = 4'b1010; ready_i = '1;
    drive_inputs(); #1;
    check_eq("post_rst_ready", FW'(ready_o), FW'(4'b0010));
    cycle();
    check_eq("post_rst_vc", FW'(vc_id_o), FW'(1));

    // random traffic, backpressure and occasional reset
    for (int k = 0; k < 600; k++) begin
      arst    = ($urandom_range(0, 39) != 0);
      gate    = N'($urandom);
      ready_i = N'($urandom);
      if ($urandom_range(0, 3) == 0) refill_all();
      cycle();
    end

    // drain everything and confirm nothing is lost
    arst = 1'b1; gate = '1; ready_i = '1;
    repeat (40) cycle();
    for (int v = 0; v < N; v++) check_eq("drain_sb", FW'(sb[v].size()), FW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
